// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display controller: register map,
// CTRL field positions and the active-low hex font.
package seg7_pkg;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SEG_W       = 8;
  localparam int unsigned MAX_DIGITS  = 8;

  localparam logic [ADDR_W-1:0] OFF_DATA = 12'h000;
  localparam logic [ADDR_W-1:0] OFF_CTRL = 12'h004;
  localparam logic [ADDR_W-1:0] OFF_DP   = 12'h008;

  // Register select is the word index within the window (addr[3:2]).
  typedef enum logic [1:0] {
    REG_DATA = 2'(OFF_DATA >> 2),
    REG_CTRL = 2'(OFF_CTRL >> 2),
    REG_DP   = 2'(OFF_DP >> 2),
    REG_RSVD = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_LZB      = 1;
  localparam int unsigned CTRL_MASK_LSB = 8;
  localparam int unsigned CTRL_MASK_W   = 8;
  localparam logic [DATA_W-1:0] CTRL_RESET = 32'h0000_0001;

  // {G,F,E,D,C,B,A}, active-low, indexed by nibble value.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to active-low {DP,G..A} pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = {~dp, HEX_FONT[nibble]};

endmodule

// File: rtl/seg7_scan.sv
// Bus-mapped, time-multiplexed 7-segment controller with masking, DPs,
// leading-zero blanking and register readback.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DIGITS-1:0] dig_en,
  output logic [SEG_W-1:0]  seg
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  reg_sel_e                sel;
  logic [DATA_W-1:0]       data_q;
  logic                    en_q;
  logic                    lzb_q;
  logic [CTRL_MASK_W-1:0]  mask_q;
  logic [DIGITS-1:0]       dp_q;
  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;

  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_mask;
  logic                    upper_zero;
  logic                    blank;
  logic [SEG_W-1:0]        glyph_c;
  logic [DIGITS-1:0]       dig_en_d;
  logic [SEG_W-1:0]        seg_d;

  logic                    unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:4], addr[1:0]};

  assign sel = reg_sel_e'(addr[3:2]);

  // Register file; reserved slot swallows writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      en_q   <= CTRL_RESET[CTRL_EN];
      lzb_q  <= CTRL_RESET[CTRL_LZB];
      mask_q <= CTRL_RESET[CTRL_MASK_LSB +: CTRL_MASK_W];
      dp_q   <= '0;
    end else if (wen) begin
      case (sel)
        REG_DATA: data_q <= wdata;
        REG_CTRL: begin
          en_q   <= wdata[CTRL_EN];
          lzb_q  <= wdata[CTRL_LZB];
          mask_q <= wdata[CTRL_MASK_LSB +: CTRL_MASK_W];
        end
        REG_DP:   dp_q <= wdata[DIGITS-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_DATA: rdata = data_q;
      REG_CTRL: begin
        rdata[CTRL_EN]                        = en_q;
        rdata[CTRL_LZB]                       = lzb_q;
        rdata[CTRL_MASK_LSB +: CTRL_MASK_W]   = mask_q;
      end
      REG_DP:   rdata = DATA_W'(dp_q);
      default:  rdata = '0;
    endcase
  end

  // Prescaler and digit index; both parked at 0 while disabled so a
  // re-enable always starts digit 0 with a full slot.
  always_ff @(posedge clk) begin
    if (rst || !en_q) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Select the active digit's fields and decide leading-zero blanking.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_mask   = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_nibble = data_q[4*i +: 4];
        cur_dp     = dp_q[i];
        cur_mask   = mask_q[i];
      end
      if (IDX_W'(i) >= idx && data_q[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    blank = cur_mask || (lzb_q && (idx != '0) && upper_zero);
  end

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg_c  (glyph_c)
  );

  always_comb begin
    dig_en_d = '1;
    seg_d    = '1;
    if (en_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig_en_d[i] = (IDX_W'(i) != idx);
      end
      if (!blank) begin
        seg_d = glyph_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en <= '1;
      seg    <= '1;
    end else begin
      dig_en <= dig_en_d;
      seg    <= seg_d;
    end
  end

endmodule
